// File: rtl/gcd_dispatcher.sv
// Streaming front end for the GCD core: an operand FIFO feeding a one-at-a-time issue FSM
// with a valid/ready result port. Define GCD_TIMEOUT_EN to abort a WAIT after TIMEOUT cycles.
module gcd_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [DW-1:0]            in_a_i,
  input  logic [DW-1:0]            in_b_i,
  output logic                     gcd_start_o,
  output logic [DW-1:0]            gcd_a_o,
  output logic [DW-1:0]            gcd_b_o,
  input  logic [DW-1:0]            gcd_y_i,
  input  logic                     gcd_done_i,
  input  logic                     gcd_error_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DW-1:0]            out_y_o,
  output logic                     out_err_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e              state_q;
  logic [2*DW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q;
  logic [AW-1:0]       rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic [CW-1:0]       count_d;
  logic                done_q;
  logic                gcd_start_q;
  logic [DW-1:0]       gcd_a_q;
  logic [DW-1:0]       gcd_b_q;
  logic                out_valid_q;
  logic [DW-1:0]       out_y_q;
  logic                out_err_q;

  logic                push_s;
  logic                pop_s;
  logic                done_evt_s;
  logic [2*DW-1:0]     head_s;

`ifdef GCD_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  logic [TW-1:0]       tmo_q;
`endif

  assign in_ready_o  = (count_q != CNT_FULL);
  assign push_s      = in_valid_i & in_ready_o;
  assign pop_s       = (state_q == S_IDLE) && (count_q != CNT_ZERO);
  // Rising-edge detect so a DONE level left over from the previous op is not re-counted.
  assign done_evt_s  = gcd_done_i & ~done_q;
  assign head_s      = mem_q[rd_ptr_q];

  assign gcd_start_o = gcd_start_q;
  assign gcd_a_o     = gcd_a_q;
  assign gcd_b_o     = gcd_b_q;
  assign out_valid_o = out_valid_q;
  assign out_y_o     = out_y_q;
  assign out_err_o   = out_err_q;
  assign count_o     = count_q;

  // Occupancy next-state from push/pop
  always_comb begin
    count_d = count_q;
    if (push_s && !pop_s) begin
      count_d = count_q + CNT_ONE;
    end else if (!push_s && pop_s) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Operand storage write port
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {in_a_i, in_b_i};
    end
  end

  // FIFO pointers, occupancy and DONE history
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
      done_q  <= gcd_done_i;
    end
  end

  // Issue FSM with registered GCD and result outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      gcd_start_q <= 1'b0;
      gcd_a_q     <= '0;
      gcd_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_err_q   <= 1'b0;
`ifdef GCD_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop_s) begin
            gcd_a_q     <= head_s[2*DW-1:DW];
            gcd_b_q     <= head_s[DW-1:0];
            gcd_start_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          gcd_start_q <= 1'b0;
          state_q     <= S_WAIT;
`ifdef GCD_TIMEOUT_EN
          tmo_q       <= '0;
`endif
        end
        S_WAIT: begin
          // A DONE edge in the same cycle as the timeout takes priority.
          if (done_evt_s) begin
            out_y_q     <= gcd_y_i;
            out_err_q   <= gcd_error_i;
            out_valid_q <= 1'b1;
            state_q     <= S_HOLD;
`ifdef GCD_TIMEOUT_EN
          end else if (tmo_q == TMO_LAST) begin
            out_y_q     <= '0;
            out_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end else begin
            tmo_q       <= tmo_q + TMO_ONE;
`endif
          end
        end
        S_HOLD: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          gcd_start_q <= 1'b0;
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_dispatcher.sv
// Self-checking bench for gcd_dispatcher: a behavioural GCD core stub plus a result scoreboard.
module tb_gcd_dispatcher;
  localparam int DEPTH   = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 10;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic          gcd_start;
  logic [DW-1:0] gcd_a, gcd_b;
  logic [DW-1:0] stub_y;
  logic          stub_done, stub_err;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_y;
  logic          out_err;
  logic [CW-1:0] count;

  gcd_dispatcher #(.DEPTH(DEPTH), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_a_i(in_a), .in_b_i(in_b),
    .gcd_start_o(gcd_start), .gcd_a_o(gcd_a), .gcd_b_o(gcd_b),
    .gcd_y_i(stub_y), .gcd_done_i(stub_done), .gcd_error_i(stub_err),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_y_o(out_y), .out_err_o(out_err), .count_o(count)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_results = 0;
  int n_pushed  = 0;
  logic [DW:0] sb[$];
  logic inflight = 1'b0;
  logic prev_start = 1'b0, prev_valid = 1'b0, prev_hs = 1'b0, prev_err = 1'b0;
  logic [DW-1:0] prev_y = '0;
  logic tmo_mode = 1'b0;
  logic stub_hang = 1'b0;

  // Reference GCD core behaviour: {ERROR, Y}; zero operand reports ERROR with Y=A.
  function automatic logic [DW:0] ref_result(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] x, y, t;
    if (a == '0 || b == '0) return {1'b1, a};
    x = a; y = b;
    while (y != '0) begin t = x % y; x = y; y = t; end
    return {1'b0, x};
  endfunction

  // GCD core stub: keeps a stale DONE high one cycle past START, then a random latency.
  int stub_cnt, stub_lat;
  logic [DW-1:0] stub_a, stub_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_done <= 1'b0; stub_y <= '0; stub_err <= 1'b0; stub_cnt <= 0; stub_lat <= 3;
      stub_a <= '0; stub_b <= '0;
    end else if (gcd_start) begin
      stub_a <= gcd_a; stub_b <= gcd_b;
      stub_lat <= $urandom_range(3, 6);
      stub_cnt <= -1;
    end else if (stub_cnt == -1) begin
      stub_cnt <= stub_lat - 1;
      stub_done <= 1'b0;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1 && !stub_hang) begin
        {stub_err, stub_y} <= ref_result(stub_a, stub_b);
        stub_done <= 1'b1;
      end
    end
  end

  // Scoreboard push/pop and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        sb.push_back(tmo_mode ? {1'b1, {DW{1'b0}}} : ref_result(in_a, in_b));
        n_pushed++;
      end
      if (gcd_start) begin
        n_tests++;
        if (inflight || prev_start) begin
          n_fail++;
          $display("FAIL start_guard: start=1 with inflight=%0b prev_start=%0b, required no overlap", inflight, prev_start);
        end
        inflight = 1'b1;
      end
      if (out_valid && prev_valid && !prev_hs) begin
        n_tests++;
        if (out_y !== prev_y || out_err !== prev_err) begin
          n_fail++;
          $display("FAIL hold_stable: y=%0d err=%0b, required y=%0d err=%0b", out_y, out_err, prev_y, prev_err);
        end
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: y=%0d err=%0b with empty scoreboard", out_y, out_err);
        end else begin
          logic [DW:0] exp_r;
          exp_r = sb.pop_front();
          if ({out_err, out_y} !== exp_r) begin
            n_fail++;
            $display("FAIL result: y=%0d err=%0b, required y=%0d err=%0b", out_y, out_err, exp_r[DW-1:0], exp_r[DW]);
          end
        end
        inflight = 1'b0;
        n_results++;
      end
      prev_start = gcd_start;
      prev_valid = out_valid;
      prev_hs    = out_valid && out_ready;
      prev_y     = out_y;
      prev_err   = out_err;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_model();
    sb.delete();
    inflight = 1'b0; prev_start = 1'b0; prev_valid = 1'b0; prev_hs = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int guard = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    while (!in_ready && guard < 500) begin tick(); guard++; end
    if (guard >= 500) begin
      n_tests++; n_fail++;
      $display("FAIL push_timeout: in_ready stuck 0 for %0d cycles, required 1", guard);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((sb.size() != 0 || inflight) && guard < 3000) begin tick(); guard++; end
    n_tests++;
    if (guard >= 3000) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    n_tests++;
    if ({count, in_ready, gcd_start, gcd_a, gcd_b, out_valid, out_y, out_err} !==
        {CW'(0), 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: count=%0d rdy=%0b st=%0b a=%0d b=%0d v=%0b y=%0d e=%0b, required 0 1 0 0 0 0 0 0",
               count, in_ready, gcd_start, gcd_a, gcd_b, out_valid, out_y, out_err);
    end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_single();
    int r0 = n_results;
    out_ready = 1'b1;
    push(8'd21, 8'd6);
    tick();
    n_tests++;
    if (gcd_start !== 1'b1 || gcd_a !== 8'd21 || gcd_b !== 8'd6) begin
      n_fail++;
      $display("FAIL single_issue: start=%0b a=%0d b=%0d, required 1 21 6", gcd_start, gcd_a, gcd_b);
    end
    tick();
    n_tests++;
    if (gcd_start !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pulse: start=%0b one cycle later, required 0", gcd_start);
    end
    drain();
    tick(2);
    n_tests++;
    if (n_results - r0 != 1) begin
      n_fail++;
      $display("FAIL single_beats: %0d results, required 1", n_results - r0);
    end
  endtask

  task automatic test_back_to_back();
    int r0 = n_results;
    out_ready = 1'b1;
    push(8'd8, 8'd17);
    push(8'd42, 8'd42);
    push(8'd128, 8'd120);
    push(8'd250, 8'd255);
    drain();
    n_tests++;
    if (n_results - r0 != 4) begin
      n_fail++;
      $display("FAIL b2b_count: %0d results, required 4", n_results - r0);
    end
  endtask

  task automatic test_full();
    int r0 = n_results;
    int p0 = n_pushed;
    logic [DW-1:0] av[6] = '{8'd12, 8'd7, 8'd100, 8'd9, 8'd14, 8'd27};
    logic [DW-1:0] bv[6] = '{8'd18, 8'd21, 8'd75, 8'd6, 8'd49, 8'd81};
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      in_a = av[i]; in_b = bv[i]; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    n_tests++;
    if (count !== CW'(DEPTH) || in_ready !== 1'b0 || n_pushed - p0 != 5) begin
      n_fail++;
      $display("FAIL full_saturate: count=%0d in_ready=%0b accepted=%0d, required 4 0 5", count, in_ready, n_pushed - p0);
    end
    tick(25);
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full_hold: out_valid=%0b with out_ready low, required 1", out_valid);
    end
    out_ready = 1'b1;
    drain();
    n_tests++;
    if (n_results - r0 != 5) begin
      n_fail++;
      $display("FAIL full_count: %0d results, required 5", n_results - r0);
    end
  endtask

  task automatic test_error();
    int r0 = n_results;
    out_ready = 1'b1;
    push(8'd0, 8'd0);
    push(8'd35, 8'd0);
    push(8'd64, 8'd128);
    drain();
    n_tests++;
    if (n_results - r0 != 3) begin
      n_fail++;
      $display("FAIL error_count: %0d results, required 3", n_results - r0);
    end
  endtask

  task automatic test_reset_mid();
    logic quiet = 1'b1;
    out_ready = 1'b1;
    push(8'd30, 8'd12);
    push(8'd45, 8'd27);
    push(8'd16, 8'd40);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({count, gcd_start, gcd_a, gcd_b, out_valid, out_y, out_err} !==
        {CW'(0), 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_state: count=%0d st=%0b a=%0d b=%0d v=%0b y=%0d e=%0b, required all 0",
               count, gcd_start, gcd_a, gcd_b, out_valid, out_y, out_err);
    end
    clear_model();
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (gcd_start !== 1'b0 || out_valid !== 1'b0) quiet = 1'b0;
      tick();
    end
    n_tests++;
    if (quiet !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_quiet: start/out_valid seen after reset, required none");
    end
  endtask

  task automatic test_timeout();
    int cycles = 0;
    out_ready = 1'b1;
    stub_hang = 1'b1;
    tmo_mode  = 1'b1;
    push(8'd9, 8'd3);
    tick();
`ifdef GCD_TIMEOUT_EN
    while (!out_valid && cycles < 100) begin tick(); cycles++; end
    n_tests++;
    if (cycles != TIMEOUT + 1 || out_y !== 8'd0 || out_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout: after %0d cycles y=%0d err=%0b, required %0d cycles y=0 err=1", cycles, out_y, out_err, TIMEOUT + 1);
    end
    drain();
`else
    while (!out_valid && cycles < 300) begin tick(); cycles++; end
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL no_timeout: out_valid=%0b after %0d cycles, required 0", out_valid, cycles);
    end
    rst_n = 1'b0;
    clear_model();
    tick(2);
    rst_n = 1'b1;
`endif
    stub_hang = 1'b0;
    tmo_mode  = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_error();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/gcd_dispatcher.md
Name: gcd_dispatcher

Overview:
- Upstream sequencer for the GCD core: buffers operand pairs in a small FIFO and issues them to GCD one at a time.
- Per operand pair: one-cycle START pulse, wait for DONE, return Y/ERROR through a valid/ready result port.
- Replaces bench-driven START/A/B sequencing with a streaming front end.

Parameters:
DEPTH, 4, operand FIFO entries; power of 2, at least 2
DW, 8, operand/result width; must match GCD A/B/Y width
TIMEOUT, 255, max cycles in WAIT before abort; used only with GCD_TIMEOUT_EN

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset; shared with GCD core
IN_VALID  in  1  operand pair offered
IN_READY  out  1  FIFO can accept (COUNT < DEPTH)
IN_A  in  DW  operand A
IN_B  in  DW  operand B
GCD_START  out  1  to GCD START; registered
GCD_A  out  DW  to GCD A; registered, held stable
GCD_B  out  DW  to GCD B; registered, held stable
GCD_Y  in  DW  from GCD Y
GCD_DONE  in  1  from GCD DONE
GCD_ERROR  in  1  from GCD ERROR
OUT_VALID  out  1  result available
OUT_READY  in  1  consumer accepts result
OUT_Y  out  DW  captured GCD result
OUT_ERR  out  1  captured GCD ERROR (or timeout)
COUNT  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, RST_N=0):
  - FIFO pointers and COUNT = 0; FSM = IDLE.
  - GCD_START = 0; GCD_A = GCD_B = 0.
  - OUT_VALID = 0; OUT_Y = 0; OUT_ERR = 0; done_d = 0.
  - Reset mid-operation discards queued and in-flight work. No result is emitted.
- FIFO:
  - Push when IN_VALID & IN_READY at a rising edge.
  - IN_READY = (COUNT != DEPTH), combinational from registered COUNT.
  - A push while full is ignored, even if a pop occurs in the same cycle.
  - Pop happens only on the IDLE->ISSUE transition.
  - Push and pop in the same cycle leaves COUNT unchanged.
  - Pointers wrap modulo DEPTH.
- DONE event: done_evt = GCD_DONE & ~done_d, where done_d is GCD_DONE registered. A level DONE left high from a prior op is never re-counted.
- FSM states IDLE, ISSUE, WAIT, HOLD:
  - IDLE: if COUNT>0, at the edge: load GCD_A/GCD_B from the FIFO head, pop, set GCD_START=1, go to ISSUE.
  - ISSUE: at the next edge: GCD_START=0, go to WAIT. START is high for exactly one clock.
  - WAIT: on done_evt, capture OUT_Y=GCD_Y and OUT_ERR=GCD_ERROR, set OUT_VALID=1, go to HOLD.
  - HOLD: OUT_Y/OUT_ERR stay stable while OUT_VALID=1. On OUT_VALID & OUT_READY at an edge: OUT_VALID=0, go to IDLE.
- GCD_A/GCD_B hold their values from ISSUE until the next IDLE->ISSUE load.
- Latency:
  - Push accepted at edge k into an empty FIFO with FSM in IDLE: GCD_START=1 from edge k+1 to edge k+2.
  - done_evt sampled at edge m: OUT_VALID=1 after edge m.
  - With OUT_READY held 1, the next START can rise at edge m+2 at the earliest.
- ERROR passthrough: zero-operand cases (e.g. 35,0 or 0,0) report whatever GCD drives on Y, with OUT_ERR=GCD_ERROR. The dispatcher does not pre-check operands.
- Pushes continue during WAIT/HOLD; the FIFO absorbs them up to DEPTH.

Optional Feature:
GCD_TIMEOUT_EN
- Defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT with no done_evt: OUT_Y=0, OUT_ERR=1, OUT_VALID=1, go to HOLD.
  - A done_evt in the same cycle as the timeout wins (normal capture).
  - A late DONE after a timeout is absorbed by the edge detector and not reported.
- Undefined: no counter. WAIT holds indefinitely until done_evt. TIMEOUT is ignored.

Test Plan:
- Reset, then push (21,6), OUT_READY=1 -> single START pulse with GCD_A=21, GCD_B=6; OUT_Y=3, OUT_ERR=0, one OUT_VALID beat.
- Back-to-back push of (8,17),(42,42),(128,120),(250,255) -> results in order: 1,42,8,5; START never asserted while FSM is in WAIT/HOLD.
- OUT_READY=0, push DEPTH+2 pairs -> COUNT saturates at 4, IN_READY=0, extra pushes dropped; OUT_Y stable while OUT_VALID=1. Release OUT_READY -> 5 results total (1 in flight + 4 queued).
- Push (0,0) and (35,0) -> OUT_ERR matches the GCD core's ERROR for each op; the following (64,128) returns 64 with OUT_ERR=0.
- Assert RST_N=0 during WAIT with 2 entries queued -> all outputs at reset values immediately; after release, no stale result and no START until a new push.
- With GCD_TIMEOUT_EN, TIMEOUT=10, GCD stub never raising DONE -> OUT_VALID after 10 WAIT cycles with OUT_Y=0, OUT_ERR=1; without the macro, OUT_VALID stays 0.
